// File: rtl/mcp3221_i2c_responder_if.sv
// Bus and sample-stream signals of the MCP3221 responder.
// The slave modport is the responder's view. The master modport is the view
// of the initiator or sample source that drives it.
interface mcp3221_i2c_responder_if;
    logic        i2c_sclk;
    logic        i2c_sda_input;
    logic        i2c_sda_output;
    logic        sda_is_output;
    logic [11:0] din_sample;
    logic        din_valid;
    logic        din_ready;
    logic [11:0] dout_sample_sent;
    logic        dout_valid;
    logic        dout_addr_match;

    modport slave (
        input  i2c_sclk, i2c_sda_input, din_sample, din_valid,
        output i2c_sda_output, sda_is_output, din_ready,
               dout_sample_sent, dout_valid, dout_addr_match
    );

    modport master (
        output i2c_sclk, i2c_sda_input, din_sample, din_valid,
        input  i2c_sda_output, sda_is_output, din_ready,
               dout_sample_sent, dout_valid, dout_addr_match
    );
endinterface

// File: rtl/mcp3221_i2c_responder.sv
// MCP3221 emulation: I2C read-only target that returns a 12-bit sample as
// {4'b0, s[11:8]}, s[7:0]. It keeps sending samples while the initiator ACKs
// the second byte.
module mcp3221_i2c_responder #(
    parameter logic [6:0] G_DEVICE_ADDRESS = 7'h4D,
    parameter int         G_SYNC_STAGES    = 2
) (
    input logic clk,
    input logic reset,
    mcp3221_i2c_responder_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_TX, ST_MACK, ST_WAIT_STOP
    } state_t;

    logic [G_SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic scl_s, sda_s, scl_d, sda_d;
    logic scl_rise, scl_fall, start_det, stop_det;

    logic [11:0] sample_hold;
    logic        din_ready;

    state_t      state, state_n;
    logic [3:0]  bit_cnt, bit_cnt_n;
    logic [7:0]  addr_sh, addr_sh_n;
    logic [7:0]  tx_sh, tx_sh_n;
    logic [7:0]  tx_load;
    logic        byte_idx, byte_idx_n;
    logic        sda_oe, sda_oe_n;
    logic [11:0] snap_reg, snap_n;
    logic [11:0] sample_sent, sent_n;
    logic        dout_valid, valid_n;
    logic        addr_match, match_n;

    assign scl_s = scl_sync[G_SYNC_STAGES-1];
    assign sda_s = sda_sync[G_SYNC_STAGES-1];

    // Synchronize SCL and SDA, then keep one history flop for edge detection.
    // Reset to 1 so that an idle bus never produces an event.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[G_SYNC_STAGES-2:0], bus.i2c_sclk};
            sda_sync <= {sda_sync[G_SYNC_STAGES-2:0], bus.i2c_sda_input};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_rise  =  scl_s & ~scl_d;
    assign scl_fall  = ~scl_s &  scl_d;
    assign start_det =  scl_s &  scl_d &  sda_d & ~sda_s;
    assign stop_det  =  scl_s &  scl_d & ~sda_d &  sda_s;

    // Sample holding register. It is always ready except in the reset cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_hold <= 12'h000;
            din_ready   <= 1'b0;
        end else begin
            din_ready <= 1'b1;
            if (bus.din_valid && din_ready) sample_hold <= bus.din_sample;
        end
    end

    // FSM and datapath register bank.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            bit_cnt     <= 4'd0;
            addr_sh     <= 8'h00;
            tx_sh       <= 8'h00;
            byte_idx    <= 1'b0;
            sda_oe      <= 1'b0;
            snap_reg    <= 12'h000;
            sample_sent <= 12'h000;
            dout_valid  <= 1'b0;
            addr_match  <= 1'b0;
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            addr_sh     <= addr_sh_n;
            tx_sh       <= tx_sh_n;
            byte_idx    <= byte_idx_n;
            sda_oe      <= sda_oe_n;
            snap_reg    <= snap_n;
            sample_sent <= sent_n;
            dout_valid  <= valid_n;
            addr_match  <= match_n;
        end
    end

    // Next-state logic. SDA changes only on a detected SCL fall (or a release
    // on START/STOP), so the responder can never create a bus condition.
    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        addr_sh_n  = addr_sh;
        tx_sh_n    = tx_sh;
        byte_idx_n = byte_idx;
        sda_oe_n   = sda_oe;
        snap_n     = snap_reg;
        sent_n     = sample_sent;
        valid_n    = 1'b0;
        match_n    = 1'b0;
        tx_load    = 8'h00;

        if (start_det) begin
            state_n   = ST_ADDR;
            bit_cnt_n = 4'd0;
            sda_oe_n  = 1'b0;
        end else if (stop_det) begin
            state_n  = ST_IDLE;
            sda_oe_n = 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_WAIT_STOP: sda_oe_n = 1'b0;
                ST_ADDR: if (scl_rise) begin
                    addr_sh_n = {addr_sh[6:0], sda_s};
                    bit_cnt_n = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        bit_cnt_n = 4'd0;
                        if (addr_sh_n[7:1] == G_DEVICE_ADDRESS && addr_sh_n[0])
                            state_n = ST_ADDR_ACK;
                        else
                            state_n = ST_WAIT_STOP;
                    end
                end
                // bit_cnt 0: waiting for the fall that starts the ACK bit.
                // bit_cnt 1: ACK is being driven, and the next fall starts byte 0.
                ST_ADDR_ACK: if (scl_fall) begin
                    if (bit_cnt == 4'd0) begin
                        sda_oe_n  = 1'b1;
                        snap_n    = sample_hold;
                        match_n   = 1'b1;
                        bit_cnt_n = 4'd1;
                    end else begin
                        tx_load    = {4'b0000, snap_reg[11:8]};
                        sda_oe_n   = ~tx_load[7];
                        tx_sh_n    = {tx_load[6:0], 1'b0};
                        bit_cnt_n  = 4'd1;
                        byte_idx_n = 1'b0;
                        state_n    = ST_TX;
                    end
                end
                // bit_cnt counts the bits already presented in this byte.
                ST_TX: if (scl_fall) begin
                    if (bit_cnt == 4'd8) begin
                        sda_oe_n  = 1'b0;
                        bit_cnt_n = 4'd0;
                        state_n   = ST_MACK;
                    end else begin
                        sda_oe_n  = ~tx_sh[7];
                        tx_sh_n   = {tx_sh[6:0], 1'b0};
                        bit_cnt_n = bit_cnt + 4'd1;
                    end
                end
                ST_MACK: begin
                    if (scl_rise && bit_cnt == 4'd0) begin
                        bit_cnt_n = 4'd1;
                        if (byte_idx) begin
                            valid_n = 1'b1;
                            sent_n  = snap_reg;
                            if (!sda_s) snap_n  = sample_hold;
                            else        state_n = ST_WAIT_STOP;
                        end
                    end else if (scl_fall && bit_cnt == 4'd1) begin
                        tx_load    = byte_idx ? {4'b0000, snap_reg[11:8]} : snap_reg[7:0];
                        sda_oe_n   = ~tx_load[7];
                        tx_sh_n    = {tx_load[6:0], 1'b0};
                        bit_cnt_n  = 4'd1;
                        byte_idx_n = ~byte_idx;
                        state_n    = ST_TX;
                    end
                end
                default: begin
                    state_n  = ST_IDLE;
                    sda_oe_n = 1'b0;
                end
            endcase
        end
    end

    assign bus.sda_is_output    = sda_oe;
    assign bus.i2c_sda_output   = ~sda_oe;
    assign bus.din_ready        = din_ready;
    assign bus.dout_sample_sent = sample_sent;
    assign bus.dout_valid       = dout_valid;
    assign bus.dout_addr_match  = addr_match;
endmodule

// File: tb/tb_mcp3221_i2c_responder.sv
// Directed bench for mcp3221_i2c_responder. A bus-level I2C initiator runs
// against the open-drain line. Expected samples are queued when the
// transaction is launched and popped at each dout_valid pulse.
`timescale 1ns/1ps
module tb_mcp3221_i2c_responder;
    localparam int HP = 10;  // clk cycles per SCL phase

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic scl   = 1'b1;
    logic m_low = 1'b0;      // initiator pulls SDA low

    int checks = 0;
    int errors = 0;
    int vcnt   = 0;
    int mcnt   = 0;
    logic oe_seen    = 1'b0;
    logic prev_valid = 1'b0;
    logic [11:0] exp_q[$];

    mcp3221_i2c_responder_if bif();
    assign bif.i2c_sclk      = scl;
    assign bif.i2c_sda_input = ~(m_low | bif.sda_is_output);

    mcp3221_i2c_responder #(.G_DEVICE_ADDRESS(7'h4D), .G_SYNC_STAGES(2)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bif.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor. It counts pulses, tracks any SDA drive, and pops the
    // scoreboard on each dout_valid pulse.
    always @(negedge clk) begin
        if (!reset) begin
            if (bif.sda_is_output) oe_seen = 1'b1;
            if (bif.dout_addr_match) mcnt++;
            if (bif.dout_valid) begin
                vcnt++;
                chk("valid_single_cycle", {31'd0, prev_valid}, 32'd0);
                checks++;
                assert (exp_q.size() > 0) else begin
                    errors++;
                    $error("FAIL unexpected_dout_valid: observed %0h expected no pulse", bif.dout_sample_sent);
                end
                if (exp_q.size() > 0) chk("dout_sample_sent", {20'd0, bif.dout_sample_sent}, {20'd0, exp_q.pop_front()});
            end
            prev_valid = bif.dout_valid;
        end
    end

    task automatic wc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [11:0] v);
        bif.din_sample = v;
        bif.din_valid  = 1'b1;
        wc(1);
        bif.din_valid  = 1'b0;
    endtask

    task automatic i2c_start();
        m_low = 1'b0; wc(HP);
        scl   = 1'b1; wc(HP);
        m_low = 1'b1; wc(HP);
        scl   = 1'b0; wc(2);
    endtask

    task automatic i2c_stop();
        m_low = 1'b1; wc(HP-2);
        scl   = 1'b1; wc(HP);
        m_low = 1'b0; wc(HP);
    endtask

    task automatic wr_bit(input logic b);
        m_low = ~b; wc(HP-2);
        scl   = 1'b1; wc(HP);
        scl   = 1'b0; wc(2);
    endtask

    task automatic rd_bit(output logic b);
        m_low = 1'b0; wc(HP-2);
        scl   = 1'b1; wc(HP/2);
        b     = bif.i2c_sda_input; wc(HP/2);
        scl   = 1'b0; wc(2);
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) wr_bit(d[i]);
        rd_bit(ack);
    endtask

    // ack=1: the initiator ACKs the byte (drives SDA low).
    task automatic rd_byte(input logic ack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            rd_bit(b);
            d[i] = b;
        end
        wr_bit(~ack);
    endtask

    initial begin
        logic       ack, b;
        logic [7:0] d;
        int v0, m0;
        bif.din_sample = 12'h000;
        bif.din_valid  = 1'b0;

        // reset
        wc(3);
        chk("rst_sda_is_output", {31'd0, bif.sda_is_output}, 32'd0);
        chk("rst_sda_output", {31'd0, bif.i2c_sda_output}, 32'd1);
        chk("rst_dout_valid", {31'd0, bif.dout_valid}, 32'd0);
        chk("rst_addr_match", {31'd0, bif.dout_addr_match}, 32'd0);
        chk("rst_sample_sent", {20'd0, bif.dout_sample_sent}, 32'h000);
        chk("rst_din_ready", {31'd0, bif.din_ready}, 32'd0);
        reset = 1'b0;
        chk("din_ready_before_edge", {31'd0, bif.din_ready}, 32'd0);
        wc(1);
        chk("din_ready_after_reset", {31'd0, bif.din_ready}, 32'd1);

        // basic read
        v0 = vcnt; m0 = mcnt;
        load(12'hABC);
        exp_q.push_back(12'hABC);
        i2c_start();
        wr_byte({7'h4D, 1'b1}, ack);
        chk("basic_addr_ack", {31'd0, ack}, 32'd0);
        rd_byte(1'b1, d); chk("basic_byte0", {24'd0, d}, 32'h0A);
        rd_byte(1'b0, d); chk("basic_byte1", {24'd0, d}, 32'hBC);
        wc(4);
        chk("basic_released_after_nack", {31'd0, bif.sda_is_output}, 32'd0);
        chk("basic_sample_sent", {20'd0, bif.dout_sample_sent}, 32'hABC);
        i2c_stop();
        chk("basic_valid_pulses", vcnt - v0, 32'd1);
        chk("basic_match_pulses", mcnt - m0, 32'd1);

        // address and direction filtering
        v0 = vcnt; m0 = mcnt; oe_seen = 1'b0;
        i2c_start();
        wr_byte({7'h4C, 1'b1}, ack);
        chk("wrong_addr_nack", {31'd0, ack}, 32'd1);
        i2c_stop();
        i2c_start();
        wr_byte({7'h4D, 1'b0}, ack);
        chk("write_dir_nack", {31'd0, ack}, 32'd1);
        i2c_stop();
        chk("filter_never_drives", {31'd0, oe_seen}, 32'd0);
        chk("filter_valid_pulses", vcnt - v0, 32'd0);
        chk("filter_match_pulses", mcnt - m0, 32'd0);

        // continuous read with a new sample loaded during the first pair
        v0 = vcnt; m0 = mcnt;
        load(12'hABC);
        exp_q.push_back(12'hABC);
        exp_q.push_back(12'h123);
        i2c_start();
        wr_byte({7'h4D, 1'b1}, ack);
        chk("cont_addr_ack", {31'd0, ack}, 32'd0);
        wc(5);
        load(12'h123);
        rd_byte(1'b1, d); chk("cont_byte0", {24'd0, d}, 32'h0A);
        rd_byte(1'b1, d); chk("cont_byte1", {24'd0, d}, 32'hBC);
        rd_byte(1'b1, d); chk("cont_byte2", {24'd0, d}, 32'h01);
        rd_byte(1'b0, d); chk("cont_byte3", {24'd0, d}, 32'h23);
        i2c_stop();
        chk("cont_valid_pulses", vcnt - v0, 32'd2);
        chk("cont_match_pulses", mcnt - m0, 32'd1);

        // STOP after 4 bits of the first data byte aborts the read
        v0 = vcnt;
        load(12'hC3E);
        i2c_start();
        wr_byte({7'h4D, 1'b1}, ack);
        chk("abort_addr_ack", {31'd0, ack}, 32'd0);
        for (int i = 0; i < 4; i++) rd_bit(b);
        i2c_stop();
        chk("abort_released", {31'd0, bif.sda_is_output}, 32'd0);
        chk("abort_no_valid", vcnt - v0, 32'd0);
        // a normal read after the abort
        exp_q.push_back(12'hC3E);
        i2c_start();
        wr_byte({7'h4D, 1'b1}, ack);
        chk("post_abort_addr_ack", {31'd0, ack}, 32'd0);
        rd_byte(1'b1, d); chk("post_abort_byte0", {24'd0, d}, 32'h0C);
        rd_byte(1'b0, d); chk("post_abort_byte1", {24'd0, d}, 32'h3E);
        i2c_stop();
        chk("post_abort_valid", vcnt - v0, 32'd1);

        // repeated START after the address ACK, then a full read
        v0 = vcnt; m0 = mcnt;
        load(12'h8F5);
        exp_q.push_back(12'h8F5);
        i2c_start();
        wr_byte({7'h4D, 1'b1}, ack);
        chk("rs_addr_ack1", {31'd0, ack}, 32'd0);
        for (int i = 0; i < 4; i++) rd_bit(b);
        i2c_start();
        wr_byte({7'h4D, 1'b1}, ack);
        chk("rs_addr_ack2", {31'd0, ack}, 32'd0);
        rd_byte(1'b1, d); chk("rs_byte0", {24'd0, d}, 32'h08);
        rd_byte(1'b0, d); chk("rs_byte1", {24'd0, d}, 32'hF5);
        i2c_stop();
        chk("rs_valid_pulses", vcnt - v0, 32'd1);
        chk("rs_match_pulses", mcnt - m0, 32'd2);

        // reset while the responder is driving the ACK
        i2c_start();
        for (int i = 7; i >= 0; i--) wr_bit(8'h9B >> i);
        m_low = 1'b0;
        wc(HP-2);
        chk("pre_reset_driving", {31'd0, bif.sda_is_output}, 32'd1);
        reset = 1'b1;
        wc(1);
        chk("midrst_sda_is_output", {31'd0, bif.sda_is_output}, 32'd0);
        chk("midrst_sample_sent", {20'd0, bif.dout_sample_sent}, 32'h000);
        chk("midrst_din_ready", {31'd0, bif.din_ready}, 32'd0);
        reset = 1'b0;
        wc(2);
        i2c_stop();

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mcp3221_i2c_responder.md
# mcp3221_i2c_responder

I2C target that emulates an MCP3221 12-bit ADC on a two-wire bus. It is the responder end of the MCP3221 read transaction. It recognises its 7-bit address with R/W=1, ACKs, then shifts out the current sample as two bytes: upper byte {4'b0, sample[11:8]}, lower byte sample[7:0]. It is used as an on-FPGA ADC stand-in and as the bus model in benches for the I2C read initiator.

## Interface

Parameters:
- G_DEVICE_ADDRESS, 7'h4D, 7-bit bus address this block answers to.
- G_SYNC_STAGES, 2, flip-flop stages on the SCL/SDA inputs (≥2).

Ports:
- clk  in  1  system clock (one clock domain).
- reset  in  1  synchronous, active-high reset.
- i2c_sclk  in  1  bus SCL (input only; no clock stretching).
- i2c_sda_input  in  1  bus SDA as seen on the pad.
- i2c_sda_output  out  1  SDA drive value; 0 whenever sda_is_output=1, 1 otherwise.
- sda_is_output  out  1  1 = pull SDA low; 0 = released (open-drain).
- din_sample  in  12  new ADC sample.
- din_valid  in  1  din_sample valid.
- din_ready  out  1  sample holding register can accept.
- dout_sample_sent  out  12  sample just delivered to the initiator.
- dout_valid  out  1  one-cycle pulse; a full 2-byte read completed.
- dout_addr_match  out  1  one-cycle pulse; address byte matched with R/W=1.

## Operation

Input conditioning:
- SCL and SDA each pass through G_SYNC_STAGES flops, then one history flop.
- Edge detection runs on synchronized values only.

Bus events:
- START: SDA falls while SCL is high.
- STOP: SDA rises while SCL is high.
- Both are detected in every state. START (including repeated START) resets the bit counter and enters ST_ADDR. STOP releases SDA and enters ST_IDLE.

Sample holding:
- din_valid && din_ready loads sample_hold (reset value 12'h000).
- din_ready = 1 in every cycle after reset except the reset cycle itself.
- A load never disturbs a byte already in the shift register.

States:
- ST_IDLE: SDA released; wait for START.
- ST_ADDR: shift SDA into an 8-bit register MSB-first on each SCL rise. After the 8th rise:
  - If [7:1]==G_DEVICE_ADDRESS and [0]==1: go to ST_ADDR_ACK.
  - Otherwise (address mismatch, or write): go to ST_WAIT_STOP and never drive; the initiator sees a NACK.
- ST_ADDR_ACK: on the SCL fall after the 8th rise, drive SDA low. Snapshot sample_hold into snap_reg and pulse dout_addr_match. On the following SCL fall, go to ST_TX with byte index 0.
- ST_TX: present the data bit MSB-first (drive low for 0, release for 1). The first bit of a byte is presented immediately on entry; each later bit is presented on an SCL fall. After the 8th bit's SCL fall, release SDA and go to ST_MACK.
- ST_MACK: sample SDA on the SCL rise.
  - Byte index 0: on the SCL fall, go to ST_TX with byte 1, whether ACK or NACK.
  - Byte index 1: pulse dout_valid and set dout_sample_sent = snap_reg.
    - If ACK (SDA=0): re-snapshot sample_hold into snap_reg and, on the SCL fall, go to ST_TX with byte 0 (continuous read).
    - If NACK: go to ST_WAIT_STOP.
- ST_WAIT_STOP: SDA released; wait for STOP or START.

## Timing

- Reset values:
  - sda_is_output=0, i2c_sda_output=1, din_ready=0.
  - dout_valid=0, dout_addr_match=0, dout_sample_sent=12'h000.
  - State ST_IDLE, snap_reg=0.
- SDA update latency: ≤ G_SYNC_STAGES+2 clk cycles after a bus SCL fall. Initiators must hold SCL low for at least G_SYNC_STAGES+4 clk cycles before their data-setup point. With an initiator divider of 10, this is satisfied for G_SYNC_STAGES=2.
- SDA sampling: occurs G_SYNC_STAGES+1 cycles after a bus SCL rise.
- SDA is only changed after an SCL fall is detected. It never changes while synchronized SCL is high, so the responder cannot create a false START or STOP.
- dout_valid and dout_addr_match are single-cycle pulses.
- A din load and a snapshot in the same cycle: the snapshot takes the old sample_hold; the new value is used at the next snapshot.
- A START or STOP in the middle of a byte aborts it immediately. SDA is released in the cycle the event is detected, and no dout_valid is generated.
- Reset mid-transaction: outputs return to their reset values in the next cycle.

## Test plan

- Reset: hold reset 3 cycles while the bus is idle -> sda_is_output=0, i2c_sda_output=1, dout_valid=0, din_ready rises the cycle after reset drops.
- Basic read: load 12'hABC, initiator reads address 7'h4D with R/W=1, ACKs byte 1, NACKs byte 2 ->
  - address ACK bit is 0,
  - bytes read are 8'h0A and 8'hBC,
  - one dout_addr_match pulse, one dout_valid pulse with dout_sample_sent=12'hABC,
  - SDA released after the NACK.
- Address and direction filtering:
  - address 7'h4C with R/W=1 -> ACK bit samples 1, sda_is_output stays 0, no pulses;
  - address 7'h4D with R/W=0 -> same result.
- Continuous read: load 12'hABC, then load 12'h123 during byte 1, initiator ACKs byte 2 ->
  - second pair is 8'h01, 8'h23,
  - two dout_valid pulses, carrying 12'hABC then 12'h123.
- Abort: issue STOP after 4 bits of byte 1 -> SDA released within G_SYNC_STAGES+2 cycles, no dout_valid. A following normal read then succeeds.
- Repeated START after the address ACK, then a full read -> one dout_valid pulse with correct data, and two dout_addr_match pulses.
